button_event_ctrl: RTL and testbench

Classifies one debounced, synchronised button level into discrete user events: short press, double click, long press and auto-repeat while held. It sits directly behind the button debouncer. It presents one event at a time to the consumer (menu FSM or register-write logic) over a valid/ready handshake. Timing is counter-based in clk cycles.

---
 rtl/button_pkg.sv | 24 ++
 rtl/button_event_ctrl_if.sv | 11 +
 rtl/event_slot.sv | 53 +++++
 rtl/button_event_ctrl.sv | 131 +++++++++++++
 tb/tb_button_event_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button event classifier: event codes and FSM state encoding.
package button_pkg;

    localparam logic [2:0] EV_NONE   = 3'd0;
    localparam logic [2:0] EV_SHORT  = 3'd1;
    localparam logic [2:0] EV_DOUBLE = 3'd2;
    localparam logic [2:0] EV_LONG   = 3'd3;
    localparam logic [2:0] EV_REPEAT = 3'd4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRESS1    = 3'd1;
    localparam logic [2:0] ST_LONG_HELD = 3'd2;
    localparam logic [2:0] ST_WAIT2     = 3'd3;
    localparam logic [2:0] ST_WAIT_REL  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_PRESS1    = ST_PRESS1,
        S_LONG_HELD = ST_LONG_HELD,
        S_WAIT2     = ST_WAIT2,
        S_WAIT_REL  = ST_WAIT_REL
    } state_t;

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event channel from the classifier to its consumer.
// Handshake: an event transfers on a clk edge where evt_valid and evt_ready are both 1;
// evt_valid/evt_code hold steady until that transfer, evt_ready may change freely.
interface button_event_ctrl_if;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/event_slot.sv
// One-entry valid/ready holding register with a sticky overflow flag for dropped pushes.
module event_slot #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         ready_i,
    input  logic         ovf_clr_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         overflow_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         ovf_q, ovf_d;
    logic         drop;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        // A push while the slot is occupied and not draining is lost; the old entry wins.
        drop    = push_i && valid_q && !ready_i;
        if (push_i && !drop) begin
            valid_d = 1'b1;
            data_d  = push_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (ovf_clr_i) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Turns a debounced button level into short/double/long/repeat events, one at a time
// through a single-entry event slot.
module button_event_ctrl
    import button_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int LONG_CYCLES   = 12_000_000,
    parameter int DCLICK_CYCLES = 4_000_000,
    parameter int REPEAT_CYCLES = 2_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_level,
    input  logic                enable,
    input  logic                ovf_clr,
    output logic                overflow,
    output logic                held,
    output state_t              dbg_state,
    button_event_ctrl_if.master evt
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             held_q;
    logic             evt_push;
    logic [2:0]       evt_push_code;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        evt_push      = 1'b0;
        evt_push_code = EV_NONE;
        cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_level) begin
                        state_d = S_PRESS1;
                        cnt_d   = '0;
                    end
                end
                S_PRESS1: begin
                    // Release is checked first so it beats the long-press terminal count.
                    if (!btn_level) begin
                        state_d = S_WAIT2;
                        cnt_d   = '0;
                    end else if (cnt_q == LONG_LAST) begin
                        evt_push      = 1'b1;
                        evt_push_code = EV_LONG;
                        state_d       = S_LONG_HELD;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_LONG_HELD: begin
                    if (!btn_level) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        evt_push      = 1'b1;
                        evt_push_code = EV_REPEAT;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_WAIT2: begin
                    // A second press on the expiry cycle still counts as a double click.
                    if (btn_level) begin
                        evt_push      = 1'b1;
                        evt_push_code = EV_DOUBLE;
                        state_d       = S_WAIT_REL;
                    end else if (cnt_q == DCLICK_LAST) begin
                        evt_push      = 1'b1;
                        evt_push_code = EV_SHORT;
                        state_d       = S_IDLE;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_WAIT_REL: begin
                    if (!btn_level) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= btn_level;
        end
    end

    event_slot #(.W(3)) u_slot (
        .clk         (clk),
        .reset       (reset),
        .push_i      (evt_push),
        .push_data_i (evt_push_code),
        .ready_i     (evt.evt_ready),
        .ovf_clr_i   (ovf_clr),
        .valid_o     (evt.evt_valid),
        .data_o      (evt.evt_code),
        .overflow_o  (overflow)
    );

    assign held      = held_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random press/release runs checked
// against a run-length reference model of the event rules.
module tb_button_event_ctrl;
    import button_pkg::*;

    localparam int CW   = 8;
    localparam int LONG = 8;
    localparam int DCL  = 4;
    localparam int REP  = 3;

    logic   clk = 1'b0;
    logic   reset, btn_level, enable, ovf_clr;
    logic   overflow, held;
    state_t dbg_state;

    button_event_ctrl_if evt_if ();

    button_event_ctrl #(
        .CNT_W(CW), .LONG_CYCLES(LONG), .DCLICK_CYCLES(DCL), .REPEAT_CYCLES(REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_level (btn_level),
        .enable    (enable),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow),
        .held      (held),
        .dbg_state (dbg_state),
        .evt       (evt_if)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] exp_q[$];
    int         exp_t[$];
    logic       lvl[$];
    int         seg_h[$];
    int         seg_l[$];
    int         seg_l0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: each press is classified from its hold length and the gap that follows it.
    task automatic build_model();
        int t, i, n;
        exp_q.delete();
        exp_t.delete();
        n = seg_h.size();
        t = seg_l0;
        i = 0;
        while (i < n) begin
            if (seg_h[i] > LONG) begin
                exp_t.push_back(t + LONG); exp_q.push_back(EV_LONG);
                for (int r = t + LONG + REP; r <= t + seg_h[i] - 1; r += REP) begin
                    exp_t.push_back(r); exp_q.push_back(EV_REPEAT);
                end
                t += seg_h[i] + seg_l[i];
                i += 1;
            end else if (seg_l[i] <= DCL && i + 1 < n) begin
                exp_t.push_back(t + seg_h[i] + seg_l[i]); exp_q.push_back(EV_DOUBLE);
                t += seg_h[i] + seg_l[i] + seg_h[i+1] + seg_l[i+1];
                i += 2;
            end else begin
                exp_t.push_back(t + seg_h[i] + DCL); exp_q.push_back(EV_SHORT);
                t += seg_h[i] + seg_l[i];
                i += 1;
            end
        end
    endtask

    task automatic run_segments(input string name);
        logic exp_v;
        lvl.delete();
        for (int j = 0; j < seg_l0; j++) lvl.push_back(1'b0);
        for (int s = 0; s < seg_h.size(); s++) begin
            for (int j = 0; j < seg_h[s]; j++) lvl.push_back(1'b1);
            for (int j = 0; j < seg_l[s]; j++) lvl.push_back(1'b0);
        end
        build_model();
        btn_level = lvl[0];
        for (int k = 0; k < lvl.size(); k++) begin
            tick();
            exp_v = (exp_t.size() > 0) && (exp_t[0] == k);
            n_cmp++;
            if (evt_if.evt_valid !== exp_v) begin
                n_bad++;
                $display("FAIL %s valid k=%0d got=%0b want=%0b", name, k, evt_if.evt_valid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (evt_if.evt_code !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL %s code k=%0d got=%0d want=%0d", name, k, evt_if.evt_code, exp_q[0]);
                end
                void'(exp_t.pop_front());
                void'(exp_q.pop_front());
            end
            if (k + 1 < lvl.size()) btn_level = lvl[k+1];
        end
    endtask

    task automatic set_segs(input int l0, input int h0, input int l1, input int h1, input int l2);
        seg_h.delete();
        seg_l.delete();
        seg_l0 = l0;
        seg_h.push_back(h0); seg_l.push_back(l1);
        if (h1 > 0) begin
            seg_h.push_back(h1); seg_l.push_back(l2);
        end
    endtask

    task automatic wait_first_valid(input int limit, output int kf);
        kf = -1;
        for (int k = 0; k < limit; k++) begin
            tick();
            if (evt_if.evt_valid === 1'b1) begin
                kf = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 5;
        if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset valid got=%0b want=0", evt_if.evt_valid); end
        if (evt_if.evt_code !== 3'd0)  begin n_bad++; $display("FAIL reset code got=%0d want=0", evt_if.evt_code); end
        if (overflow !== 1'b0)         begin n_bad++; $display("FAIL reset overflow got=%0b want=0", overflow); end
        if (held !== 1'b0)             begin n_bad++; $display("FAIL reset held got=%0b want=0", held); end
        if (dbg_state !== S_IDLE)      begin n_bad++; $display("FAIL reset state got=%0d want=0", dbg_state); end
        reset = 1'b0;
    endtask

    task automatic test_short();
        set_segs(2, 3, 10, 0, 0);
        run_segments("short");
    endtask

    task automatic test_double();
        set_segs(2, 3, 2, 3, 10);
        run_segments("double");
    endtask

    task automatic test_long();
        set_segs(2, 20, 8, 0, 0);
        run_segments("long");
        n_cmp++;
        if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL long_idle state got=%0d want=0", dbg_state); end
    endtask

    task automatic test_window_edge();
        set_segs(2, 3, DCL, 3, 10);
        run_segments("window_edge");
        set_segs(2, 3, DCL + 1, 3, 10);
        run_segments("window_after");
        set_segs(2, LONG, 6, 0, 0);
        run_segments("press_edge");
    endtask

    task automatic test_random();
        int npairs;
        for (int run = 0; run < 4; run++) begin
            seg_h.delete();
            seg_l.delete();
            seg_l0 = 2;
            npairs = $urandom_range(4, 8);
            for (int p = 0; p < npairs; p++) begin
                seg_h.push_back(($urandom_range(0, 3) == 0) ? LONG + $urandom_range(0, 1) : $urandom_range(1, 14));
                seg_l.push_back(($urandom_range(0, 3) == 0) ? DCL + $urandom_range(0, 1) : $urandom_range(1, 6));
            end
            seg_l[npairs-1] = DCL + 3;
            run_segments("random");
        end
    endtask

    task automatic test_back_to_back();
        evt_if.evt_ready = 1'b0;
        btn_level = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 9) begin
                n_cmp += 2;
                if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_long valid got=%0b want=1", evt_if.evt_valid); end
                if (evt_if.evt_code !== EV_LONG) begin n_bad++; $display("FAIL b2b_long code got=%0d want=%0d", evt_if.evt_code, EV_LONG); end
            end
            if (k == 10) evt_if.evt_ready = 1'b1;
            if (k == 11) begin
                n_cmp += 3;
                if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rep valid got=%0b want=1", evt_if.evt_valid); end
                if (evt_if.evt_code !== EV_REPEAT) begin n_bad++; $display("FAIL b2b_rep code got=%0d want=%0d", evt_if.evt_code, EV_REPEAT); end
                if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_rep overflow got=%0b want=0", overflow); end
                btn_level = 1'b0;
            end
            if (k == 12) begin
                n_cmp++;
                if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain valid got=%0b want=0", evt_if.evt_valid); end
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_overflow();
        evt_if.evt_ready = 1'b0;
        btn_level = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            tick();
            if (k == 9) begin
                n_cmp += 2;
                if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early overflow got=%0b want=0", overflow); end
                if (evt_if.evt_code !== EV_LONG) begin n_bad++; $display("FAIL ovf_early code got=%0d want=%0d", evt_if.evt_code, EV_LONG); end
            end
            if (k == 12) begin
                n_cmp++;
                if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set overflow got=%0b want=1", overflow); end
            end
            if (k == 14) begin
                n_cmp++;
                if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins overflow got=%0b want=1", overflow); end
                btn_level = 1'b0;
            end
            ovf_clr = (k == 13);
        end
        tick();
        n_cmp += 3;
        if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_hold valid got=%0b want=1", evt_if.evt_valid); end
        if (evt_if.evt_code !== EV_LONG) begin n_bad++; $display("FAIL ovf_hold code got=%0d want=%0d", evt_if.evt_code, EV_LONG); end
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_hold overflow got=%0b want=1", overflow); end
        evt_if.evt_ready = 1'b1;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp += 2;
        if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_clear valid got=%0b want=0", evt_if.evt_valid); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear overflow got=%0b want=0", overflow); end
    endtask

    task automatic test_reset_mid();
        int kf;
        // Reset while in LONG_HELD with EV_LONG pending and the button still down.
        evt_if.evt_ready = 1'b0;
        btn_level = 1'b1;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        n_cmp += 5;
        if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_long valid got=%0b want=0", evt_if.evt_valid); end
        if (evt_if.evt_code !== 3'd0)  begin n_bad++; $display("FAIL rst_long code got=%0d want=0", evt_if.evt_code); end
        if (overflow !== 1'b0)         begin n_bad++; $display("FAIL rst_long overflow got=%0b want=0", overflow); end
        if (held !== 1'b0)             begin n_bad++; $display("FAIL rst_long held got=%0b want=0", held); end
        if (dbg_state !== S_IDLE)      begin n_bad++; $display("FAIL rst_long state got=%0d want=0", dbg_state); end
        reset = 1'b0;
        evt_if.evt_ready = 1'b1;
        wait_first_valid(20, kf);
        n_cmp++;
        if (kf != LONG) begin n_bad++; $display("FAIL rst_relong latency got=%0d want=%0d", kf, LONG); end
        btn_level = 1'b0;
        repeat (6) tick();
        // Reset while in WAIT2 with EV_SHORT pending.
        evt_if.evt_ready = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            btn_level = (k < 2) || (k == 8) || (k == 9);
            tick();
        end
        n_cmp += 2;
        if (evt_if.evt_code !== EV_SHORT) begin n_bad++; $display("FAIL rst_w2_pending code got=%0d want=%0d", evt_if.evt_code, EV_SHORT); end
        if (dbg_state !== S_WAIT2) begin n_bad++; $display("FAIL rst_w2_pending state got=%0d want=%0d", dbg_state, S_WAIT2); end
        reset = 1'b1;
        tick();
        n_cmp += 3;
        if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_w2 valid got=%0b want=0", evt_if.evt_valid); end
        if (evt_if.evt_code !== 3'd0)  begin n_bad++; $display("FAIL rst_w2 code got=%0d want=0", evt_if.evt_code); end
        if (dbg_state !== S_IDLE)      begin n_bad++; $display("FAIL rst_w2 state got=%0d want=0", dbg_state); end
        reset = 1'b0;
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_w2_quiet valid k=%0d got=%0b want=0", k, evt_if.evt_valid); end
        end
    endtask

    task automatic test_enable();
        int kf;
        btn_level = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        tick();
        btn_level = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) enable = 1'b1;
            tick();
            n_cmp++;
            if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL en_abandon valid k=%0d got=%0b want=0", k, evt_if.evt_valid); end
        end
        enable = 1'b0;
        btn_level = 1'b1;
        repeat (2) tick();
        n_cmp += 2;
        if (held !== 1'b1) begin n_bad++; $display("FAIL en_held held got=%0b want=1", held); end
        if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL en_forced state got=%0d want=0", dbg_state); end
        enable = 1'b1;
        wait_first_valid(20, kf);
        n_cmp++;
        if (kf != LONG) begin n_bad++; $display("FAIL en_relong latency got=%0d want=%0d", kf, LONG); end
        btn_level = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        reset = 1'b1;
        btn_level = 1'b0;
        enable = 1'b1;
        ovf_clr = 1'b0;
        evt_if.evt_ready = 1'b1;
        test_reset();
        test_short();
        test_double();
        test_long();
        test_window_edge();
        test_random();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
